// File: rtl/qfrag_seq_pkg.sv
// Shared op/state encodings for the logic-cell bank sequencer.
package qfrag_seq_pkg;

    typedef enum logic [1:0] {
        OP_CAPTURE = 2'd0,
        OP_LOAD    = 2'd1,
        OP_CLEAR   = 2'd2,
        OP_PRESET  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/qfrag_expect.sv
// Expected-bank-value and readback-mismatch compute; purely combinational.
// CAPTURE loads unknown CZI data, so it never flags a mismatch.
module qfrag_expect
    import qfrag_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] qz,
    output logic             err
);

    logic [WIDTH-1:0] expected;

    always_comb begin
        expected = qz;
        case (op)
            OP_LOAD:    expected = (prev & ~mask) | (data & mask);
            OP_CLEAR:   expected = prev & ~mask;
            OP_PRESET:  expected = prev | mask;
            OP_CAPTURE: expected = qz;
            default:    expected = qz;
        endcase
        err = (op != OP_CAPTURE) && (qz != expected);
    end

endmodule

// File: rtl/qfrag_bank_seq.sv
// Pulse sequencer for a bank of logic-cell flops; response valid 3+SETTLE edges after accept.
// One command in flight; cmd_ready low from accept until the response is consumed via rsp_ready.
module qfrag_bank_seq
    import qfrag_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             QCK,
    input  logic             QRT,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] bank_qst,
    output logic [WIDTH-1:0] bank_qrt,
    output logic [WIDTH-1:0] bank_qen,
    output logic [WIDTH-1:0] bank_qds,
    output logic [WIDTH-1:0] bank_qdi,
    input  logic [WIDTH-1:0] bank_qz,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               rdy_q, rdy_d;
    logic [WIDTH-1:0]   qst_q, qst_d;
    logic [WIDTH-1:0]   qrt_q, qrt_d;
    logic [WIDTH-1:0]   qen_q, qen_d;
    logic [WIDTH-1:0]   qds_q, qds_d;
    logic [WIDTH-1:0]   qdi_q, qdi_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               exp_err;

    qfrag_expect #(.WIDTH(WIDTH)) u_expect (
        .op   (op_q),
        .mask (mask_q),
        .data (data_q),
        .prev (prev_q),
        .qz   (bank_qz),
        .err  (exp_err)
    );

    // Bank controls are registered, so they trail the DRIVE state by one cycle;
    // RELEASE therefore spans that drive-visible cycle plus SETTLE recovery cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        mask_d     = mask_q;
        data_d     = data_q;
        prev_d     = prev_q;
        qst_d      = '0;
        qrt_d      = '0;
        qen_d      = '0;
        qds_d      = '0;
        qdi_d      = '0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (rdy_q && cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    mask_d  = cmd_mask;
                    data_d  = cmd_data;
                    prev_d  = bank_qz;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                case (op_q)
                    OP_CAPTURE: qen_d = mask_q;
                    OP_LOAD: begin
                        qen_d = mask_q;
                        qds_d = mask_q;
                        qdi_d = data_q & mask_q;
                    end
                    OP_CLEAR:   qrt_d = mask_q;
                    OP_PRESET:  qst_d = mask_q;
                    default:    qst_d = '0;
                endcase
                cnt_d   = CNT_W'(SETTLE);
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                rsp_data_d = bank_qz;
                rsp_err_d  = exp_err;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_CAPTURE;
            mask_q     <= '0;
            data_q     <= '0;
            prev_q     <= '0;
            rdy_q      <= 1'b0;
            qst_q      <= '0;
            qrt_q      <= '0;
            qen_q      <= '0;
            qds_q      <= '0;
            qdi_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            prev_q     <= prev_d;
            rdy_q      <= rdy_d;
            qst_q      <= qst_d;
            qrt_q      <= qrt_d;
            qen_q      <= qen_d;
            qds_q      <= qds_d;
            qdi_q      <= qdi_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign cmd_ready = rdy_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign bank_qst  = qst_q;
    assign bank_qrt  = qrt_q;
    assign bank_qen  = qen_q;
    assign bank_qds  = qds_q;
    assign bank_qdi  = qdi_q;

endmodule

// File: tb/tb_qfrag_bank_seq.sv
// Randomised bench for qfrag_bank_seq with a behavioural flop bank and a spec-level reference model.
module tb_qfrag_bank_seq;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int LAT = 3 + S;

    logic         QCK = 1'b0;
    logic         QRT = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [W-1:0] cmd_mask = '0;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] bank_qst, bank_qrt, bank_qen, bank_qds, bank_qdi, bank_qz;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_err;

    int checks   = 0;
    int failures = 0;

    always #5 QCK = ~QCK;

    qfrag_bank_seq #(.WIDTH(W), .SETTLE(S)) dut (
        .QCK(QCK), .QRT(QRT),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_mask(cmd_mask), .cmd_data(cmd_data),
        .bank_qst(bank_qst), .bank_qrt(bank_qrt), .bank_qen(bank_qen),
        .bank_qds(bank_qds), .bank_qdi(bank_qdi), .bank_qz(bank_qz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // Behavioural logic-cell flops: set beats reset beats enable; QDS picks QDI over CZI.
    logic [W-1:0] bank_q = '0;
    logic [W-1:0] czi    = '0;
    logic [W-1:0] stuck  = '0;

    always @(posedge QCK) begin
        for (int i = 0; i < W; i++) begin
            if (bank_qst[i])      bank_q[i] <= 1'b1;
            else if (bank_qrt[i]) bank_q[i] <= 1'b0;
            else if (bank_qen[i]) bank_q[i] <= bank_qds[i] ? bank_qdi[i] : czi[i];
        end
    end
    assign bank_qz = ((bank_q | bank_qst) & ~(bank_qrt & ~bank_qst)) | stuck;

    // Reference: internal bank contents after each command.
    logic [W-1:0] ref_bank = '0;

    function automatic logic [W-1:0] bank_after(input logic [1:0] op, input logic [W-1:0] b,
                                                input logic [W-1:0] m, input logic [W-1:0] d,
                                                input logic [W-1:0] c);
        case (op)
            2'd0:    return (b & ~m) | (c & m);
            2'd1:    return (b & ~m) | (d & m);
            2'd2:    return b & ~m;
            default: return b | m;
        endcase
    endfunction

    function automatic logic readback_bad(input logic [1:0] op, input logic [W-1:0] p,
                                          input logic [W-1:0] m, input logic [W-1:0] d,
                                          input logic [W-1:0] q);
        case (op)
            2'd1:    return q != ((p & ~m) | (d & m));
            2'd2:    return q != (p & ~m);
            2'd3:    return q != (p | m);
            default: return 1'b0;
        endcase
    endfunction

    // Observations from the last command
    int           o_lat, o_wait, o_qst_cyc;
    logic         o_conflict, o_any_ctl, o_rdy_low_ok, o_stable_ok, o_rdy_after, o_valid_after;
    logic [W-1:0] o_qst, o_qrt, o_qen, o_qds, o_qdi, o_data;
    logic         o_err;

    task automatic tick();
        @(posedge QCK);
        #1;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] m, input logic [W-1:0] d,
                           input int hold);
        int n;
        o_lat = -1; o_qst_cyc = 0; o_conflict = 0; o_any_ctl = 0;
        o_rdy_low_ok = 1; o_stable_ok = 1;
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = m; cmd_data = d; rsp_ready = 1'b0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        o_wait = n;
        tick();
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom_range(3)); cmd_mask = W'($urandom); cmd_data = W'($urandom);
        for (int k = 0; k < 30; k++) begin
            if (bank_qst != '0) o_qst_cyc++;
            if ((bank_qst | bank_qrt | bank_qen | bank_qds | bank_qdi) != '0) o_any_ctl = 1;
            if ((bank_qst & bank_qrt) != '0 || ((bank_qst | bank_qrt) != '0 && bank_qen != '0))
                o_conflict = 1;
            if (k == 1) begin
                o_qst = bank_qst; o_qrt = bank_qrt; o_qen = bank_qen;
                o_qds = bank_qds; o_qdi = bank_qdi;
            end
            if (rsp_valid) begin
                o_lat = k;
                break;
            end
            if (cmd_ready) o_rdy_low_ok = 0;
            tick();
        end
        o_data = rsp_data;
        o_err  = rsp_err;
        cmd_valid = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            if (cmd_ready) o_rdy_low_ok = 0;
            if (!rsp_valid || rsp_data !== o_data || rsp_err !== o_err) o_stable_ok = 0;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        o_rdy_after   = cmd_ready;
        o_valid_after = rsp_valid;
    endtask

    // Runs one command and checks response against the reference model
    task automatic exec_check(input string name, input logic [1:0] op, input logic [W-1:0] m,
                              input logic [W-1:0] d, input int hold);
        logic [W-1:0] prev_obs, new_ref, new_obs;
        logic         want_err;
        prev_obs = ref_bank | stuck;
        new_ref  = bank_after(op, ref_bank, m, d, czi);
        new_obs  = new_ref | stuck;
        want_err = readback_bad(op, prev_obs, m, d, new_obs);
        run_cmd(op, m, d, hold);
        ref_bank = new_ref;
        checks++;
        if (o_lat !== LAT) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, o_lat, LAT);
        end
        checks++;
        if (o_data !== new_obs) begin
            failures++;
            $display("FAIL %s rsp_data: got %h expected %h", name, o_data, new_obs);
        end
        checks++;
        if (o_err !== want_err) begin
            failures++;
            $display("FAIL %s rsp_err: got %b expected %b", name, o_err, want_err);
        end
        checks++;
        if (o_conflict !== 1'b0 || o_rdy_low_ok !== 1'b1) begin
            failures++;
            $display("FAIL %s ctl_overlap_or_ready: got conflict=%b rdy_ok=%b expected 0/1",
                     name, o_conflict, o_rdy_low_ok);
        end
        checks++;
        if (o_qst_cyc !== ((op == 2'd3 && m != '0) ? 1 : 0)) begin
            failures++;
            $display("FAIL %s qst_cycles: got %0d expected %0d", name, o_qst_cyc,
                     (op == 2'd3 && m != '0) ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        QRT = 1'b1;
        tick();
        tick();
        checks++;
        if ({bank_qst, bank_qrt, bank_qen, bank_qds, bank_qdi} !== '0 ||
            rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got ctl=%h valid=%b data=%h err=%b ready=%b expected all 0",
                     {bank_qst, bank_qrt, bank_qen, bank_qds, bank_qdi}, rsp_valid, rsp_data,
                     rsp_err, cmd_ready);
        end
        QRT = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
        ref_bank = bank_q;
    endtask

    task automatic test_preset();
        exec_check("preset", 2'd3, 8'hFF, 8'h00, 0);
        checks++;
        if (o_qst !== 8'hFF || o_qen !== 8'h00) begin
            failures++;
            $display("FAIL preset_drive: got qst=%h qen=%h expected ff/00", o_qst, o_qen);
        end
    endtask

    task automatic test_load();
        exec_check("load", 2'd1, 8'h0F, 8'h05, 0);
        checks++;
        if (o_qen !== 8'h0F || o_qds !== 8'h0F || o_qdi !== 8'h05 || o_data !== 8'hF5) begin
            failures++;
            $display("FAIL load_drive: got qen=%h qds=%h qdi=%h data=%h expected 0f/0f/05/f5",
                     o_qen, o_qds, o_qdi, o_data);
        end
    endtask

    task automatic test_clear_stuck();
        exec_check("clear", 2'd2, 8'hF0, 8'h00, 0);
        checks++;
        if (o_data !== 8'h05 || o_qrt !== 8'hF0) begin
            failures++;
            $display("FAIL clear_value: got data=%h qrt=%h expected 05/f0", o_data, o_qrt);
        end
        stuck = 8'h80;
        exec_check("stuck", 2'd2, 8'h80, 8'h00, 0);
        checks++;
        if (o_err !== 1'b1) begin
            failures++;
            $display("FAIL stuck_err: got %b expected 1", o_err);
        end
        stuck = '0;
    endtask

    task automatic test_capture();
        czi = 8'hAA;
        exec_check("capture", 2'd0, 8'h3C, 8'h00, 0);
        checks++;
        if (o_qds !== 8'h00 || o_qen !== 8'h3C || o_data !== 8'h29) begin
            failures++;
            $display("FAIL capture_drive: got qds=%h qen=%h data=%h expected 00/3c/29",
                     o_qds, o_qen, o_data);
        end
    endtask

    task automatic test_mask_zero();
        exec_check("mask0", 2'd1, 8'h00, 8'hFF, 0);
        checks++;
        if (o_any_ctl !== 1'b0) begin
            failures++;
            $display("FAIL mask0_ctl: got any_ctl=%b expected 0", o_any_ctl);
        end
    endtask

    task automatic test_back_to_back();
        exec_check("hold", 2'd3, 8'h11, 8'h00, 10);
        checks++;
        if (o_stable_ok !== 1'b1 || o_rdy_after !== 1'b1 || o_valid_after !== 1'b0) begin
            failures++;
            $display("FAIL hold_resp: got stable=%b ready_after=%b valid_after=%b expected 1/1/0",
                     o_stable_ok, o_rdy_after, o_valid_after);
        end
        exec_check("b2b", 2'd2, 8'h10, 8'h00, 0);
        checks++;
        if (o_wait !== 0) begin
            failures++;
            $display("FAIL b2b_accept: got wait=%0d expected 0", o_wait);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_valid;
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_mask = 8'hC0; cmd_data = '0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        ref_bank = ref_bank | 8'hC0;
        QRT = 1'b1;
        tick();
        checks++;
        if ({bank_qst, bank_qrt, bank_qen, bank_qds, bank_qdi} !== '0 || rsp_valid !== 1'b0 ||
            cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: got ctl=%h valid=%b ready=%b expected 0/0/0",
                     {bank_qst, bank_qrt, bank_qen, bank_qds, bank_qdi}, rsp_valid, cmd_ready);
        end
        QRT = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready: got %b expected 1", cmd_ready);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_noresp: got rsp_valid seen=%b expected 0", seen_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            czi   = W'($urandom);
            stuck = ($urandom_range(9) == 0) ? W'(1 << $urandom_range(W - 1)) : '0;
            exec_check("random", 2'($urandom_range(3)), W'($urandom), W'($urandom),
                       ($urandom_range(3) == 0) ? int'($urandom_range(4)) : 0);
        end
        stuck = '0;
    endtask

    initial begin
        test_reset();
        test_preset();
        test_load();
        test_clear_stuck();
        test_capture();
        test_mask_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
